// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter and stage D forwarding.
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned WBR_VALID = 5;
  localparam int unsigned WBR_W     = REG_IDX_W + 1;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [WBR_W-1:0]  wbr;
    logic [DATA_W-1:0] res;
  } rf_write_t;

  // Writeback target for a real write to register idx.
  function automatic logic [WBR_W-1:0] make_wbr(input logic [REG_IDX_W-1:0] idx);
    return {1'b1, idx};
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester and register-file write-port signals of the write arbiter.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic                 m_valid;
  logic [WBR_W-1:0]     m_wbr;
  logic [DATA_W-1:0]    m_res;
  logic                 s_valid;
  logic                 s_ready;
  logic [REG_IDX_W-1:0] s_wbr;
  logic [DATA_W-1:0]    s_res;
  logic                 rf_we;
  logic [WBR_W-1:0]     rf_wbr;
  logic [DATA_W-1:0]    rf_res;
  logic                 init_done;
  logic                 stall_req;

  modport master (
    output m_valid, m_wbr, m_res, s_valid, s_wbr, s_res,
    input  s_ready, rf_we, rf_wbr, rf_res, init_done, stall_req
  );

  modport slave (
    input  m_valid, m_wbr, m_res, s_valid, s_wbr, s_res,
    output s_ready, rf_we, rf_wbr, rf_res, init_done, stall_req
  );

endinterface

// File: rtl/regfile_write_arbiter_init_seq.sv
// Post-reset clear sequencer: walks r0..r(NREGS-1) once and then raises done.
module regfile_init_seq
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 last_c,
  output logic                 done
);

  assign last_c = en & (idx == REG_IDX_W'(NREGS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      idx  <= '0;
      done <= 1'b0;
    end else if (en) begin
      idx <= idx + REG_IDX_W'(1);
      if (last_c) done <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port owner for the dual-copy register file: clears it after reset,
// then merges M-stage commits with a secondary producer. Optional starvation stall: RF_ARB_STARVE_STALL_EN.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned NREGS        = 32
) (
  input logic                    clock,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  arb_state_e           state_q, state_d;
  rf_write_t            wr_q, wr_d;
  logic [REG_IDX_W-1:0] init_idx;
  logic                 init_last_c;
  logic                 init_done;
  logic                 m_write_c;
  logic                 s_ready_c;

  regfile_init_seq #(.NREGS(NREGS)) u_init_seq (
    .clock  (clock),
    .reset  (reset),
    .en     (state_q == ST_INIT),
    .idx    (init_idx),
    .last_c (init_last_c),
    .done   (init_done)
  );

  assign m_write_c = bus.m_valid & bus.m_wbr[WBR_VALID];
  assign s_ready_c = init_done & bus.s_valid & ~m_write_c;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_last_c) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Next write-port value; data holds when the port is idle.
  always_comb begin
    wr_d     = wr_q;
    wr_d.we  = 1'b0;
    wr_d.wbr = '0;
    case (state_q)
      ST_INIT: begin
        wr_d.we  = 1'b1;
        wr_d.wbr = make_wbr(init_idx);
        wr_d.res = '0;
      end
      ST_RUN: begin
        if (m_write_c) begin
          wr_d.we  = 1'b1;
          wr_d.wbr = bus.m_wbr;
          wr_d.res = bus.m_res;
        end else if (s_ready_c && (bus.s_wbr != '0)) begin
          // r0 is handshaken but never written so bypass sees wbr bit5 low.
          wr_d.we  = 1'b1;
          wr_d.wbr = make_wbr(bus.s_wbr);
          wr_d.res = bus.s_res;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) wr_q <= '0;
    else       wr_q <= wr_d;
  end

  assign bus.rf_we     = wr_q.we;
  assign bus.rf_wbr    = wr_q.wbr;
  assign bus.rf_res    = wr_q.res;
  assign bus.init_done = init_done;
  assign bus.s_ready   = s_ready_c;

`ifdef RF_ARB_STARVE_STALL_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                stall_q, stall_d;

  // Count lost arbitration rounds; the stall pulse itself clears the count.
  always_comb begin
    starve_d = starve_q;
    if ((state_q != ST_RUN) || !bus.s_valid || s_ready_c || stall_q)
      starve_d = '0;
    else if (starve_q != STARVE_W'(STARVE_LIMIT))
      starve_d = starve_q + STARVE_W'(1);
    stall_d = (starve_d == STARVE_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.stall_req = stall_q;
`else
  assign bus.stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default and RF_ARB_STARVE_STALL_EN builds).
module tb_regfile_write_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.STARVE_LIMIT(8), .NREGS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_valid = 1'b0;
    bus.m_wbr   = '0;
    bus.m_res   = '0;
    bus.s_valid = 1'b0;
    bus.s_wbr   = '0;
    bus.s_res   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    bus.s_valid = 1'b1;
    #1;
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_wbr !== 6'h00 || bus.rf_res !== 32'h0) begin
      failures++;
      $display("FAIL reset_rf we=%b wbr=%h res=%h expected 0/00/0", bus.rf_we, bus.rf_wbr, bus.rf_res);
    end
    checks++;
    if (bus.s_ready !== 1'b0 || bus.init_done !== 1'b0 || bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl s_ready=%b init_done=%b stall=%b expected 0/0/0",
               bus.s_ready, bus.init_done, bus.stall_req);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset_mid_init();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.init_done !== 1'b0) begin
      failures++;
      $display("FAIL midinit_reset we=%b init_done=%b expected 0/0", bus.rf_we, bus.init_done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wbr !== 6'h20 || bus.init_done !== 1'b0) begin
      failures++;
      $display("FAIL midinit_restart we=%b wbr=%h init_done=%b expected 1/20/0",
               bus.rf_we, bus.rf_wbr, bus.init_done);
    end
    // Finish the restarted sequence: 31 more writes.
    for (int i = 1; i < 32; i++) tick();
    checks++;
    if (bus.rf_wbr !== 6'h3F || bus.init_done !== 1'b1) begin
      failures++;
      $display("FAIL midinit_finish wbr=%h init_done=%b expected 3f/1", bus.rf_wbr, bus.init_done);
    end
  endtask

  task automatic test_init_clear();
    logic [5:0] exp_wbr;
    int         bad;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      bus.m_valid = 1'b1;
      bus.m_wbr   = 6'h2A;
      bus.m_res   = 32'hFFFF_FFFF;
      bus.s_valid = (i < 31);
      tick();
      exp_wbr = 6'h20 + 6'(i);
      checks++;
      if (bus.rf_we !== 1'b1 || bus.rf_wbr !== exp_wbr || bus.rf_res !== 32'h0 ||
          bus.init_done !== (i == 31)) begin
        failures++;
        bad++;
        $display("FAIL init_write%0d we=%b wbr=%h res=%h done=%b expected 1/%h/0/%b",
                 i, bus.rf_we, bus.rf_wbr, bus.rf_res, bus.init_done, exp_wbr, (i == 31));
      end
      if (i < 31) begin
        checks++;
        if (bus.s_ready !== 1'b0) begin
          failures++;
          $display("FAIL init_s_ready%0d s_ready=%b expected 0", i, bus.s_ready);
        end
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_wbr !== 6'h00 || bus.init_done !== 1'b1) begin
      failures++;
      $display("FAIL run_idle we=%b wbr=%h done=%b expected 0/00/1", bus.rf_we, bus.rf_wbr, bus.init_done);
    end
  endtask

  task automatic test_m_priority();
    bus.m_valid = 1'b1;
    bus.m_wbr   = 6'h25;
    bus.m_res   = 32'hDEAD_BEEF;
    bus.s_valid = 1'b1;
    bus.s_wbr   = 5'd3;
    bus.s_res   = 32'hAAAA_5555;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL mprio_s_ready s_ready=%b expected 0", bus.s_ready);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wbr !== 6'h25 || bus.rf_res !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL mprio_write we=%b wbr=%h res=%h expected 1/25/deadbeef", bus.rf_we, bus.rf_wbr, bus.rf_res);
    end
    bus.m_valid = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL mprio_s_after s_ready=%b expected 1", bus.s_ready);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wbr !== 6'h23 || bus.rf_res !== 32'hAAAA_5555) begin
      failures++;
      $display("FAIL mprio_pending_s we=%b wbr=%h res=%h expected 1/23/aaaa5555", bus.rf_we, bus.rf_wbr, bus.rf_res);
    end
    idle_inputs();
  endtask

  task automatic test_secondary();
    bus.s_valid = 1'b1;
    bus.s_wbr   = 5'd7;
    bus.s_res   = 32'h1234_5678;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL sec_s_ready s_ready=%b expected 1", bus.s_ready);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wbr !== 6'h27 || bus.rf_res !== 32'h1234_5678) begin
      failures++;
      $display("FAIL sec_write we=%b wbr=%h res=%h expected 1/27/12345678", bus.rf_we, bus.rf_wbr, bus.rf_res);
    end
    bus.s_valid = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL sec_idle_ready s_ready=%b expected 0", bus.s_ready);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_wbr !== 6'h00 || bus.rf_res !== 32'h1234_5678) begin
      failures++;
      $display("FAIL sec_idle_hold we=%b wbr=%h res=%h expected 0/00/12345678", bus.rf_we, bus.rf_wbr, bus.rf_res);
    end
  endtask

  task automatic test_r0_write();
    bus.s_valid = 1'b1;
    bus.s_wbr   = 5'd0;
    bus.s_res   = 32'hCAFE_F00D;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL r0_s_ready s_ready=%b expected 1", bus.s_ready);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_wbr !== 6'h00) begin
      failures++;
      $display("FAIL r0_no_write we=%b wbr=%h expected 0/00", bus.rf_we, bus.rf_wbr);
    end
    idle_inputs();
  endtask

  task automatic test_m_not_write();
    bus.m_valid = 1'b1;
    bus.m_wbr   = 6'h05;
    bus.m_res   = 32'h0BAD_0BAD;
    bus.s_valid = 1'b1;
    bus.s_wbr   = 5'd9;
    bus.s_res   = 32'h0000_0099;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL mnowr_s_ready s_ready=%b expected 1", bus.s_ready);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wbr !== 6'h29 || bus.rf_res !== 32'h0000_0099) begin
      failures++;
      $display("FAIL mnowr_write we=%b wbr=%h res=%h expected 1/29/00000099", bus.rf_we, bus.rf_wbr, bus.rf_res);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  wbrs [3];
    logic [31:0] ress [3];
    wbrs = '{6'h21, 6'h3F, 6'h30};
    ress = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    for (int i = 0; i < 3; i++) begin
      bus.m_valid = 1'b1;
      bus.m_wbr   = wbrs[i];
      bus.m_res   = ress[i];
      tick();
      checks++;
      if (bus.rf_we !== 1'b1 || bus.rf_wbr !== wbrs[i] || bus.rf_res !== ress[i]) begin
        failures++;
        $display("FAIL b2b_%0d we=%b wbr=%h res=%h expected 1/%h/%h",
                 i, bus.rf_we, bus.rf_wbr, bus.rf_res, wbrs[i], ress[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starve();
    logic exp_stall;
`ifdef RF_ARB_STARVE_STALL_EN
    exp_stall = 1'b1;
`else
    exp_stall = 1'b0;
`endif
    bus.s_valid = 1'b1;
    bus.s_wbr   = 5'd10;
    bus.s_res   = 32'h5A5A_5A5A;
    for (int i = 1; i <= 8; i++) begin
      bus.m_valid = 1'b1;
      bus.m_wbr   = 6'h20 + 6'(i);
      bus.m_res   = 32'(i);
      #1;
      checks++;
      if (bus.s_ready !== 1'b0) begin
        failures++;
        $display("FAIL starve_ready%0d s_ready=%b expected 0", i, bus.s_ready);
      end
      tick();
      checks++;
      if (bus.stall_req !== ((i == 8) ? exp_stall : 1'b0)) begin
        failures++;
        $display("FAIL starve_stall%0d stall_req=%b expected %b", i, bus.stall_req, (i == 8) ? exp_stall : 1'b0);
      end
    end
    bus.m_valid = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL starve_grant s_ready=%b expected 1", bus.s_ready);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wbr !== 6'h2A || bus.rf_res !== 32'h5A5A_5A5A || bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL starve_write we=%b wbr=%h res=%h stall=%b expected 1/2a/5a5a5a5a/0",
               bus.rf_we, bus.rf_wbr, bus.rf_res, bus.stall_req);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_reset_mid_init();
    test_init_clear();
    test_m_priority();
    test_secondary();
    test_r0_write();
    test_m_not_write();
    test_back_to_back();
    test_starve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the decode-stage dual-copy register file (regs_A/regs_B).
- After reset, sequences a hardware clear of r0..r31, because power-up register contents are otherwise undefined in synthesis.
- In normal operation, merges two requesters onto the port:
  - the M-stage commit, which always wins and is never back-pressured;
  - a secondary long-latency producer (future mul/div unit or debug write), using a valid/ready handshake.
- Sits between stage M / secondary unit and the register file; its registered outputs drive the write port and the W-stage bypass.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles a pending secondary request may lose arbitration before a pipeline stall is requested (see Optional Feature).
- NREGS, 32: number of architectural registers cleared during init; index width is 5.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- m_valid  in  1  M-stage commit valid.
- m_wbr  in  6  M-stage writeback reg; bit5 = real write, [4:0] = index.
- m_res  in  32  M-stage result.
- s_valid  in  1  secondary write request.
- s_ready  out  1  secondary request accepted this cycle.
- s_wbr  in  5  secondary destination index.
- s_res  in  32  secondary data.
- rf_we  out  1  register-file write enable (registered).
- rf_wbr  out  6  registered write target, {1'b1,index} when rf_we, else 0.
- rf_res  out  32  registered write data.
- init_done  out  1  high once the clear sequence has finished.
- stall_req  out  1  request to freeze the pipeline front end for one cycle.

Behaviour:
- Reset values: rf_we=0, rf_wbr=0, rf_res=0, s_ready=0, init_done=0, stall_req=0, init counter=0, starve counter=0.
- The reset state is INIT. Reset asserted in any state, including mid-INIT, returns to INIT with the counter at 0.
- INIT state:
  - each cycle: rf_we=1, rf_wbr={1,cnt}, rf_res=0, cnt++;
  - after writing index NREGS-1 (32 cycles), go to RUN and set init_done=1 on the same edge;
  - s_ready=0 throughout;
  - m_valid is ignored; stage F is held off by ~init_done, so no commits occur.
- RUN state, per cycle:
  - m_write = m_valid & m_wbr[5].
  - If m_write: next rf_we=1, rf_wbr=m_wbr, rf_res=m_res; s_ready=0.
  - Else if s_valid: s_ready=1 (combinational in the same cycle); next rf_we=1, rf_wbr={1,s_wbr}, rf_res=s_res.
  - Else: next rf_we=0, rf_wbr=0. rf_res holds its last value.
- s_ready is combinational: init_done & s_valid & ~m_write. A transfer occurs when s_valid & s_ready.
- Write latency is one cycle from request to rf_we for both paths.
- The secondary requester holds s_valid, s_wbr and s_res stable until s_ready.
- s_wbr == 0: accepted and handshaken, but rf_we stays 0. This preserves the r0-never-written invariant that the bypass network relies on (wbr bit5 = 0).
- Starve counter (RUN only):
  - increments each cycle s_valid & ~s_ready, saturating at STARVE_LIMIT;
  - clears on an accepted transfer or when s_valid is low.
- No internal buffering: exactly one write per cycle, and nothing is ever dropped.

Optional Feature:
- Macro: RF_ARB_STARVE_STALL_EN.
- Defined:
  - when the starve counter equals STARVE_LIMIT, stall_req is asserted, registered, for exactly one cycle;
  - the pipeline guarantees m_valid=0 in the following cycle, so the secondary is granted there;
  - the counter then clears.
- Undefined: stall_req is tied to 0 and the secondary may starve indefinitely. The counter logic is omitted.

Decomposition:
- Shared package/include: state encoding (ST_INIT=0, ST_RUN=1), the WBR_VALID bit position (5), and the REG_IDX_W=5 constant. These are reused by stage D forwarding.
- One natural sub-module, regfile_init_seq: the INIT counter plus the done flag, reusable for the CP0 register clear.
- Arbitration logic stays in the top module.

Test Plan:
- Reset released at cycle 0 → rf_we=1 with rf_wbr 0x20..0x3F and rf_res=0 on cycles 1..32; init_done=1 after the 32nd write.
- Reset reasserted at cycle 10 of INIT → counter restarts; the next write targets 0x20; init_done stays 0.
- RUN, m_valid=1, m_wbr=0x25, m_res=0xDEADBEEF, with s_valid=1 simultaneously → s_ready=0; next cycle rf_wbr=0x25, rf_res=0xDEADBEEF.
- RUN, m idle, s_valid=1, s_wbr=7, s_res=0x12345678 → s_ready=1 that cycle; next cycle rf_we=1, rf_wbr=0x27, rf_res=0x12345678.
- RUN, s_wbr=0, s_valid=1, m idle → handshake completes; rf_we=0 and rf_wbr=0 next cycle.
- With RF_ARB_STARVE_STALL_EN and STARVE_LIMIT=8: m_write held high, s_valid high → stall_req pulses one cycle after the 8th blocked cycle. Force m_valid=0 next → s granted. Without the macro: stall_req never asserts.
